// File: rtl/me_pkg.sv
// -----------------------------------------------------------------------------
// me_pkg
// Shared definitions for the ME result path: the default SAD width, the
// search-window centre, the motion-vector and block-index widths, and the bit
// offsets of the packed motion-vector record. The ME wrapper and the
// downstream writer both use this package.
//
// Record layout (LSB first):
//   sad    [SAD_BIT_WIDTH-1:0]
//   mv_x   [MV_W-1:0]
//   mv_y   [MV_W-1:0]
//   blk_x  [BLK_W-1:0]
//   blk_y  [BLK_W-1:0]
// -----------------------------------------------------------------------------
package me_pkg;

  localparam int SAD_BIT_WIDTH = 14;
  localparam int MV_OFFSET     = 8;
  localparam int MV_W          = 6;
  localparam int BLK_W         = 8;

  // Field offsets for a record built with the default SAD width.
  localparam int REC_SAD_LSB   = 0;
  localparam int REC_MV_X_LSB  = SAD_BIT_WIDTH;
  localparam int REC_MV_Y_LSB  = REC_MV_X_LSB + MV_W;
  localparam int REC_BLK_X_LSB = REC_MV_Y_LSB + MV_W;
  localparam int REC_BLK_Y_LSB = REC_BLK_X_LSB + BLK_W;
  localparam int REC_W         = REC_BLK_Y_LSB + BLK_W;

  // Signed motion-vector component: zero-extended search index minus the
  // window centre, kept as MV_W-bit two's complement (range -8..+23).
  function automatic logic [MV_W-1:0] mv_from_index(input logic [4:0] idx,
                                                    input int offset);
    logic [MV_W-1:0] ext;
    ext = {1'b0, idx};
    return ext - MV_W'(offset);
  endfunction

endpackage

// File: rtl/me_result_fifo.sv
// -----------------------------------------------------------------------------
// me_result_fifo
// Parameterized synchronous first-word-fall-through FIFO. The head entry is
// visible on data_o whenever valid_o is high. A push while full is accepted
// only if a pop happens in the same cycle; otherwise it is ignored (the
// caller decides what a drop means). A pop while empty is ignored.
//
// Ports:
//   clk_i    in   clock
//   rst_ni   in   asynchronous active-low reset (empties the FIFO)
//   push_i   in   write data_i this cycle
//   data_i   in   WIDTH-bit entry to write
//   pop_i    in   consume the head entry this cycle
//   data_o   out  head entry (stable until popped)
//   valid_o  out  FIFO holds at least one entry
//   full_o   out  FIFO holds DEPTH entries
// -----------------------------------------------------------------------------
module me_result_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic             do_push_s;
  logic             do_pop_s;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop_s  = pop_i & valid_q;
  assign do_push_s = push_i & (~full_q | do_pop_s);

  // Next-state pointers, occupancy and registered flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != CW'(0));
    full_d  = (count_d == CW'(DEPTH));
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
    end
  end

  // Storage; cleared on reset so the head output reads zero while empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = valid_q;
  assign full_o  = full_q;

endmodule

// File: rtl/me_result_collector.sv
// -----------------------------------------------------------------------------
// me_result_collector
// Sink at the output of the ME engine. Each 0->1 transition of data_valid
// captures one result, converts the column/row search indices into a signed
// motion vector, tags it with the block coordinates inside the frame and
// pushes the record into a small FWFT FIFO for a valid/ready writer.
//
// Optional feature: define ME_COLLECT_SADACC_EN to add frame_sad_o, the SAD
// total of the last completed frame (updated together with frame_done_o).
//
// Ports:
//   clk           in   clock
//   rst           in   asynchronous active-low reset
//   frame_start   in   synchronous frame restart (clears position/accumulator)
//   MSAD          in   minimum SAD
//   MSAD_column   in   column index of the minimum
//   MSAD_row      in   row index of the minimum
//   data_valid    in   result-valid level; captured on its rising edge
//   mv_data_o     out  {blk_y, blk_x, mv_y, mv_x, sad}
//   mv_valid_o    out  FIFO head valid
//   mv_ready_i    in   downstream accept
//   frame_done_o  out  one-cycle pulse after the last block of a frame
//   overflow_o    out  sticky: a record was dropped on a full FIFO
//   frame_sad_o   out  (ME_COLLECT_SADACC_EN only) last frame SAD total
// -----------------------------------------------------------------------------
module me_result_collector
  import me_pkg::*;
#(
  parameter int SAD_BIT_WIDTH = me_pkg::SAD_BIT_WIDTH,
  parameter int MV_OFFSET     = me_pkg::MV_OFFSET,
  parameter int BLOCKS_X      = 40,
  parameter int BLOCKS_Y      = 30,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_start,
  input  logic [SAD_BIT_WIDTH-1:0]    MSAD,
  input  logic [4:0]                  MSAD_column,
  input  logic [4:0]                  MSAD_row,
  input  logic                        data_valid,
  output logic [SAD_BIT_WIDTH+27:0]   mv_data_o,
  output logic                        mv_valid_o,
  input  logic                        mv_ready_i,
  output logic                        frame_done_o,
  output logic                        overflow_o
`ifdef ME_COLLECT_SADACC_EN
  ,
  output logic [SAD_BIT_WIDTH+11:0]   frame_sad_o
`endif
);

  localparam int RW = SAD_BIT_WIDTH + 28;

  logic             dv_q;
  logic             cap_s;
  logic [BLK_W-1:0] blk_x_q, blk_x_d;
  logic [BLK_W-1:0] blk_y_q, blk_y_d;
  logic [BLK_W-1:0] tag_x_s, tag_y_s;
  logic             x_last_s, y_last_s;
  logic             frame_done_q, frame_done_d;
  logic             overflow_q, overflow_d;
  logic [MV_W-1:0]  mv_x_s, mv_y_s;
  logic [RW-1:0]    rec_s;
  logic             fifo_valid_s;
  logic             fifo_full_s;
  logic [RW-1:0]    fifo_data_s;

  // dv_q resets high so a level already high after reset is not an edge.
  assign cap_s = data_valid & ~dv_q;

  // A coincident frame_start makes this capture the first block of a frame.
  assign tag_x_s  = frame_start ? '0 : blk_x_q;
  assign tag_y_s  = frame_start ? '0 : blk_y_q;
  assign x_last_s = (tag_x_s == BLK_W'(BLOCKS_X - 1));
  assign y_last_s = (tag_y_s == BLK_W'(BLOCKS_Y - 1));

  assign mv_x_s = mv_from_index(MSAD_column, MV_OFFSET);
  assign mv_y_s = mv_from_index(MSAD_row, MV_OFFSET);
  assign rec_s  = {tag_y_s, tag_x_s, mv_y_s, mv_x_s, MSAD};

  // Block position, frame completion and overflow next state.
  always_comb begin
    blk_x_d      = tag_x_s;
    blk_y_d      = tag_y_s;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    if (cap_s) begin
      if (x_last_s) begin
        blk_x_d = '0;
        if (y_last_s) begin
          blk_y_d      = '0;
          frame_done_d = 1'b1;
        end else begin
          blk_y_d = tag_y_s + BLK_W'(1);
        end
      end else begin
        blk_x_d = tag_x_s + BLK_W'(1);
      end
      // Drop only when full and the head is not leaving this cycle.
      if (fifo_full_s && !(fifo_valid_s && mv_ready_i)) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end else begin
      blk_x_d = tag_x_s;
    end
  end

  // Edge detector, position counters and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dv_q         <= 1'b1;
      blk_x_q      <= '0;
      blk_y_q      <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      dv_q         <= data_valid;
      blk_x_q      <= blk_x_d;
      blk_y_q      <= blk_y_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  me_result_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (cap_s),
    .data_i  (rec_s),
    .pop_i   (mv_ready_i),
    .data_o  (fifo_data_s),
    .valid_o (fifo_valid_s),
    .full_o  (fifo_full_s)
  );

  assign mv_data_o    = fifo_data_s;
  assign mv_valid_o   = fifo_valid_s;
  assign frame_done_o = frame_done_q;
  assign overflow_o   = overflow_q;

`ifdef ME_COLLECT_SADACC_EN
  localparam int AW = SAD_BIT_WIDTH + 12;

  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] acc_base_s;
  logic [AW-1:0] acc_sum_s;
  logic [AW-1:0] frame_sad_q, frame_sad_d;

  assign acc_base_s = frame_start ? '0 : acc_q;
  assign acc_sum_s  = acc_base_s + {{12{1'b0}}, MSAD};

  // Running SAD sum; the completed total is latched with frame_done.
  always_comb begin
    acc_d       = acc_base_s;
    frame_sad_d = frame_start ? '0 : frame_sad_q;
    if (cap_s) begin
      if (x_last_s && y_last_s) begin
        frame_sad_d = acc_sum_s;
        acc_d       = '0;
      end else begin
        acc_d = acc_sum_s;
      end
    end else begin
      acc_d = acc_base_s;
    end
  end

  // Accumulator and latched frame total.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q       <= '0;
      frame_sad_q <= '0;
    end else begin
      acc_q       <= acc_d;
      frame_sad_q <= frame_sad_d;
    end
  end

  assign frame_sad_o = frame_sad_q;
`endif

endmodule

// File: tb/tb_me_result_collector.sv
// Directed bench for me_result_collector on a 2x2-block frame, 4-entry FIFO.
module tb_me_result_collector;

  localparam int SW = 14;
  localparam int RW = SW + 28;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame_start = 1'b0;
  logic [SW-1:0] MSAD = '0;
  logic [4:0]    MSAD_column = 5'd0;
  logic [4:0]    MSAD_row = 5'd0;
  logic          data_valid = 1'b1;
  logic [RW-1:0] mv_data_o;
  logic          mv_valid_o;
  logic          mv_ready_i = 1'b0;
  logic          frame_done_o;
  logic          overflow_o;
`ifdef ME_COLLECT_SADACC_EN
  logic [SW+11:0] frame_sad_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  me_result_collector #(
    .SAD_BIT_WIDTH (SW),
    .MV_OFFSET     (8),
    .BLOCKS_X      (2),
    .BLOCKS_Y      (2),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .MSAD         (MSAD),
    .MSAD_column  (MSAD_column),
    .MSAD_row     (MSAD_row),
    .data_valid   (data_valid),
    .mv_data_o    (mv_data_o),
    .mv_valid_o   (mv_valid_o),
    .mv_ready_i   (mv_ready_i),
    .frame_done_o (frame_done_o),
    .overflow_o   (overflow_o)
`ifdef ME_COLLECT_SADACC_EN
    ,
    .frame_sad_o  (frame_sad_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] rec(input logic [7:0] by, input logic [7:0] bx,
                                        input logic [5:0] my, input logic [5:0] mx,
                                        input logic [SW-1:0] sad);
    return {by, bx, my, mx, sad};
  endfunction

  // One rising edge of data_valid; returns at the negedge after the capture edge.
  task automatic pulse(input logic [SW-1:0] sad, input logic [4:0] col, input logic [4:0] row,
                       input logic fs, input logic rdy);
    @(negedge clk);
    data_valid  = 1'b0;
    frame_start = 1'b0;
    @(negedge clk);
    MSAD        = sad;
    MSAD_column = col;
    MSAD_row    = row;
    data_valid  = 1'b1;
    frame_start = fs;
    mv_ready_i  = rdy;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic fstart();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  initial begin
    // Reset held with data_valid high.
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(mv_valid_o), 64'd0);
    chk("rst_data", 64'(mv_data_o), 64'd0);
    chk("rst_done", 64'(frame_done_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0 || i == 9) chk("held_high_nocap", 64'(mv_valid_o), 64'd0);
    end

    // Centre of the window, first block.
    pulse(14'd123, 5'd8, 5'd8, 1'b0, 1'b0);
    chk("centre_valid", 64'(mv_valid_o), 64'd1);
    chk("centre_rec", 64'(mv_data_o), 64'(rec(8'd0, 8'd0, 6'd0, 6'd0, 14'd123)));
    repeat (2) @(negedge clk);
    chk("held_no_recap", 64'(mv_data_o), 64'(rec(8'd0, 8'd0, 6'd0, 6'd0, 14'd123)));
    mv_ready_i = 1'b1;
    @(negedge clk);
    mv_ready_i = 1'b0;
    chk("pop_empty", 64'(mv_valid_o), 64'd0);

    // Extreme vector, second block (1,0).
    pulse(14'd5, 5'd0, 5'd23, 1'b0, 1'b0);
    chk("neg_mv_rec", 64'(mv_data_o), 64'(rec(8'd0, 8'd1, 6'h0F, 6'h38, 14'd5)));
    mv_ready_i = 1'b1;
    @(negedge clk);
    mv_ready_i = 1'b0;

    // Full 2x2 frame with ready high.
    fstart();
    pulse(14'd10, 5'd9, 5'd8, 1'b0, 1'b1);
    chk("f0_rec", 64'(mv_data_o), 64'(rec(8'd0, 8'd0, 6'd0, 6'd1, 14'd10)));
    chk("f0_done", 64'(frame_done_o), 64'd0);
    pulse(14'd20, 5'd8, 5'd7, 1'b0, 1'b1);
    chk("f1_rec", 64'(mv_data_o), 64'(rec(8'd0, 8'd1, 6'h3F, 6'd0, 14'd20)));
    pulse(14'd30, 5'd31, 5'd8, 1'b0, 1'b1);
    chk("f2_rec", 64'(mv_data_o), 64'(rec(8'd1, 8'd0, 6'd0, 6'd23, 14'd30)));
    chk("f2_done", 64'(frame_done_o), 64'd0);
    pulse(14'd40, 5'd8, 5'd8, 1'b0, 1'b1);
    chk("f3_rec", 64'(mv_data_o), 64'(rec(8'd1, 8'd1, 6'd0, 6'd0, 14'd40)));
    chk("f3_done", 64'(frame_done_o), 64'd1);
`ifdef ME_COLLECT_SADACC_EN
    chk("frame_sad", 64'(frame_sad_o), 64'd100);
`endif
    @(negedge clk);
    chk("done_one_cycle", 64'(frame_done_o), 64'd0);
    pulse(14'd50, 5'd8, 5'd8, 1'b0, 1'b1);
    chk("wrap_rec", 64'(mv_data_o), 64'(rec(8'd0, 8'd0, 6'd0, 6'd0, 14'd50)));

    // frame_start coincident with capture at position (1,0).
    pulse(14'd60, 5'd8, 5'd8, 1'b1, 1'b1);
    chk("fs_cap_rec", 64'(mv_data_o), 64'(rec(8'd0, 8'd0, 6'd0, 6'd0, 14'd60)));
    pulse(14'd61, 5'd8, 5'd8, 1'b0, 1'b1);
    chk("fs_cap_next", 64'(mv_data_o), 64'(rec(8'd0, 8'd1, 6'd0, 6'd0, 14'd61)));
    @(negedge clk);
    chk("drained", 64'(mv_valid_o), 64'd0);

    // Overflow: five captures into a four-entry FIFO.
    fstart();
    for (int i = 1; i <= 5; i++) begin
      pulse(SW'(i), 5'd8, 5'd8, 1'b0, 1'b0);
      if (i == 4) chk("ovf_before", 64'(overflow_o), 64'd0);
    end
    chk("ovf_set", 64'(overflow_o), 64'd1);
    mv_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_drain_valid", 64'(mv_valid_o), 64'd1);
      chk("ovf_drain_sad", 64'(mv_data_o[SW-1:0]), 64'(i));
      @(negedge clk);
    end
    chk("ovf_drain_empty", 64'(mv_valid_o), 64'd0);
    mv_ready_i = 1'b0;
    fstart();
    chk("ovf_sticky", 64'(overflow_o), 64'd1);

    // Full with simultaneous pop: push accepted.
    for (int i = 11; i <= 14; i++) pulse(SW'(i), 5'd8, 5'd8, 1'b0, 1'b0);
    pulse(14'd15, 5'd8, 5'd8, 1'b0, 1'b1);
    for (int i = 12; i <= 15; i++) begin
      chk("fullpop_sad", 64'(mv_data_o[SW-1:0]), 64'(i));
      @(negedge clk);
    end
    chk("fullpop_empty", 64'(mv_valid_o), 64'd0);

    // Reset mid-operation.
    pulse(14'd77, 5'd8, 5'd8, 1'b0, 1'b0);
    chk("pre_rst_valid", 64'(mv_valid_o), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(mv_valid_o), 64'd0);
    chk("mid_rst_ovf", 64'(overflow_o), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_nocap", 64'(mv_valid_o), 64'd0);
    pulse(14'd88, 5'd8, 5'd8, 1'b0, 1'b0);
    chk("post_rst_rec", 64'(mv_data_o), 64'(rec(8'd0, 8'd0, 6'd0, 6'd0, 14'd88)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/me_result_collector.md
Name: me_result_collector

Overview:
- Sink at the output end of the ME engine. Consumes the MSAD, MSAD_column, MSAD_row and data_valid result interface.
- Turns each per-block result into a signed motion-vector record tagged with block coordinates. Buffers records in a small FIFO for a valid/ready downstream writer.
- Tracks block position within the frame and pulses frame completion.

Parameters:
- SAD_BIT_WIDTH, 14, width of MSAD.
- MV_OFFSET, 8, search-window centre subtracted from column and row.
- BLOCKS_X, 40, blocks per frame row.
- BLOCKS_Y, 30, block rows per frame.
- FIFO_DEPTH, 4, record FIFO entries (power of 2, at least 2).

Ports:
- clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-low
- frame_start  in  1  synchronous frame restart pulse
- MSAD  in  SAD_BIT_WIDTH  minimum SAD from ME
- MSAD_column  in  5  column index of MSAD
- MSAD_row  in  5  row index of MSAD
- data_valid  in  1  ME result-valid level
- mv_data_o  out  SAD_BIT_WIDTH+28  record {blk_y[7:0], blk_x[7:0], mv_y[5:0], mv_x[5:0], sad}
- mv_valid_o  out  1  FIFO head valid
- mv_ready_i  in  1  downstream accept
- frame_done_o  out  1  one-cycle pulse on last block of frame
- overflow_o  out  1  sticky: record dropped on full FIFO

Behaviour:
- Reset values while rst low: all outputs 0; FIFO empty; blk_x=blk_y=0; dv_q (registered data_valid) =1, so a high data_valid after reset never captures.
- Capture: cap = data_valid & ~dv_q, a 0->1 edge. Exactly one capture per low-to-high transition; a held-high level does not recapture.
- Arithmetic: mv_x = {1'b0,MSAD_column} - MV_OFFSET and mv_y = {1'b0,MSAD_row} - MV_OFFSET, as 6-bit two's complement with range -8..+23. sad = MSAD, unmodified.
- On cap at edge N, the record is pushed at edge N. mv_valid_o is high after edge N if the FIFO was empty (1-cycle latency).
- FIFO is first-word-fall-through. Pop when mv_valid_o & mv_ready_i. mv_data_o is stable while mv_valid_o & ~mv_ready_i.
- Full with pop in the same cycle: the push is accepted. Full with no pop: the record is dropped, overflow_o is set and held until reset.
- Empty with cap in the same cycle: no pop occurs, and mv_valid_o rises next cycle.
- Position counters advance on every cap, including dropped records.
  - blk_x increments; at BLOCKS_X-1 it wraps to 0 and blk_y increments.
  - At blk_x=BLOCKS_X-1 and blk_y=BLOCKS_Y-1, both wrap to 0 and frame_done_o pulses the following cycle.
- frame_start clears blk_x, blk_y and the accumulator; it does not clear the FIFO or overflow_o. If frame_start and cap coincide, the record is tagged (0,0) and the counter becomes (1,0).
- State machine: IDLE (dv_q=1 or waiting) -> ARMED (data_valid low seen) -> capture on the rising edge -> back to ARMED once data_valid falls again. Implementation may collapse this to dv_q.
- Reset mid-operation: FIFO contents are lost and counters cleared. No record is emitted for a result in flight.

Optional Feature:
- Macro ME_COLLECT_SADACC_EN.
- When defined: adds output frame_sad_o [SAD_BIT_WIDTH+11:0], a running sum of sad over captured blocks. It is cleared by reset and by frame_start. When a frame completes, it latches the frame total, and the accumulator restarts with the next cap. frame_sad_o updates in the same cycle as frame_done_o.
- When undefined: no port and no accumulator logic.

Decomposition:
- Shared package me_pkg holds:
  - SAD_BIT_WIDTH, MV_OFFSET, and the MV width of 6.
  - The block-index width of 8.
  - Record field offsets for mv_data_o, used by both the ME wrapper and the downstream writer.
- One natural sub-module: me_result_fifo, a parameterized synchronous FWFT FIFO with full, empty and push/pop.

Test Plan:
- Reset with data_valid=1, hold high for 10 cycles -> mv_valid_o stays 0, no capture.
- data_valid 0->1 with MSAD=123, col=8, row=8 -> one cycle later mv_data_o has sad=123, mv_x=0, mv_y=0, blk (0,0).
- col=0, row=23 -> mv_x=6'h38 (-8), mv_y=6'h0F (+15).
- BLOCKS_X=2, BLOCKS_Y=2, four captures with mv_ready_i=1 -> tags (0,0),(1,0),(0,1),(1,1); frame_done_o pulses once after the 4th; the 5th capture is tagged (0,0).
- FIFO_DEPTH=4, mv_ready_i=0, 5 captures -> 4 records retained, overflow_o=1. Then mv_ready_i=1 -> first 4 records drain in order.
- With ME_COLLECT_SADACC_EN, 2x2 frame with SADs 10, 20, 30, 40 -> frame_sad_o=100 coincident with frame_done_o.
